// File: rtl/alu_pipe_if.sv
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Handshake/data bundle between an issuer and alu_pipe.
//                The master drives the operation and the result-ready signal.
//                The slave, which is the ALU, drives in_ready and the result
//                channel.
//  Ports       : in_valid/in_ready handshake; data_operandA/B; ctrl_ALUopcode;
//                ctrl_shiftamt; in_tag; out_valid/out_ready handshake;
//                data_result; isNotEqual/isLessThan/overflow/illegal_op flags;
//                out_tag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [4:0]       ctrl_ALUopcode;
  logic [SHW-1:0]   ctrl_shiftamt;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             isNotEqual;
  logic             isLessThan;
  logic             overflow;
  logic             illegal_op;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode,
           ctrl_shiftamt, in_tag, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan,
           overflow, illegal_op, out_tag
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode,
           ctrl_shiftamt, in_tag, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan,
           overflow, illegal_op, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshakes and a tag
//                carried with each operation. Supports ADD, SUB, AND, OR, SLL,
//                SRA, SRL, ROTR and XOR. Stage 1 captures the operation and
//                precomputes the adder. Stage 2 captures the muxed result and
//                flags and drives the result channel.
//  Ports       : clock - rising-edge clock
//                reset - synchronous, active-high
//                bus   - alu_pipe_if slave: operation in, result out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic      clock,
  input  logic      reset,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] c_OP_ADD  = 5'd0;
  localparam logic [4:0] c_OP_SUB  = 5'd1;
  localparam logic [4:0] c_OP_AND  = 5'd2;
  localparam logic [4:0] c_OP_OR   = 5'd3;
  localparam logic [4:0] c_OP_SLL  = 5'd4;
  localparam logic [4:0] c_OP_SRA  = 5'd5;
  localparam logic [4:0] c_OP_SRL  = 5'd6;
  localparam logic [4:0] c_OP_ROTR = 5'd7;
  localparam logic [4:0] c_OP_XOR  = 5'd8;

  localparam logic [SHW:0] c_WIDTH_EXT = (SHW + 1)'(WIDTH);

  // Stage 1 registers
  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [4:0]       op_q;
  logic [SHW-1:0]   amt_q;
  logic [TAG_W-1:0] tag1_q;
  logic             ovf1_q;

  // Stage 2 registers and their next-state values
  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [TAG_W-1:0] tag2_q;

  logic             w_stall;
  logic [WIDTH-1:0] w_b_prime;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [SHW:0]     w_lamt;

  // A held result blocks the whole pipe; reset forces in_ready high even when
  // a stalled result is sitting in stage 2.
  assign w_stall      = s2_valid_q & ~bus.out_ready;
  assign bus.in_ready = reset | ~w_stall;

  // Subtraction adds the two's complement of B; overflow is judged on the
  // sign of that effective operand.
  assign w_b_prime = (bus.ctrl_ALUopcode == c_OP_SUB) ? (~bus.data_operandB + WIDTH'(1))
                                                      : bus.data_operandB;
  assign w_sum     = bus.data_operandA + w_b_prime;
  assign w_ovf     = (bus.data_operandA[MSB] == w_b_prime[MSB]) &
                     (w_sum[MSB] != bus.data_operandA[MSB]);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (!w_stall) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_q    <= bus.data_operandA;
        b_q    <= bus.data_operandB;
        op_q   <= bus.ctrl_ALUopcode;
        amt_q  <= bus.ctrl_shiftamt;
        tag1_q <= bus.in_tag;
        sum_q  <= w_sum;
        ovf1_q <= w_ovf;
      end
    end
  end

  // Left-shift distance for the rotate; equals WIDTH when amt is 0, which
  // shifts everything out so the rotate degenerates to A.
  assign w_lamt = c_WIDTH_EXT - {1'b0, amt_q};

  always_comb begin
    result_d = '0;
    ne_d     = 1'b0;
    lt_d     = 1'b0;
    ovf_d    = 1'b0;
    ill_d    = 1'b0;
    case (op_q)
      c_OP_ADD: begin
        result_d = sum_q;
        ovf_d    = ovf1_q;
      end
      c_OP_SUB: begin
        result_d = sum_q;
        ovf_d    = ovf1_q;
        ne_d     = (a_q != b_q);
        lt_d     = sum_q[MSB] ^ ovf1_q;
      end
      c_OP_AND:  result_d = a_q & b_q;
      c_OP_OR:   result_d = a_q | b_q;
      c_OP_SLL:  result_d = a_q << amt_q;
      c_OP_SRA:  result_d = $signed(a_q) >>> amt_q;
      c_OP_SRL:  result_d = a_q >> amt_q;
      c_OP_ROTR: result_d = (a_q >> amt_q) | (a_q << w_lamt);
      c_OP_XOR:  result_d = a_q ^ b_q;
      default:   ill_d    = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ne_q       <= 1'b0;
      lt_q       <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
      tag2_q     <= '0;
    end else if (!w_stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ne_q     <= ne_d;
        lt_q     <= lt_d;
        ovf_q    <= ovf_d;
        ill_q    <= ill_d;
        tag2_q   <= tag1_q;
      end
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.data_result = result_q;
  assign bus.isNotEqual  = ne_q;
  assign bus.isLessThan  = lt_q;
  assign bus.overflow    = ovf_q;
  assign bus.illegal_op  = ill_q;
  assign bus.out_tag     = tag2_q;
endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed self-checking bench for alu_pipe (WIDTH 32 and 16).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_pipe;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3,
                         SLL = 5'd4, SRA = 5'd5, SRL = 5'd6, ROTR = 5'd7,
                         XOR_ = 5'd8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();
  alu_pipe_if #(.WIDTH(16), .TAG_W(4)) bus16 ();

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut   (.clock(clk), .reset(rst), .bus(bus.slave));
  alu_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (.clock(clk), .reset(rst), .bus(bus16.slave));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] amt, input logic [3:0] tag);
    bus.in_valid       = 1'b1;
    bus.ctrl_ALUopcode = op;
    bus.data_operandA  = a;
    bus.data_operandB  = b;
    bus.ctrl_shiftamt  = amt;
    bus.in_tag         = tag;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] res, input logic ne,
                            input logic lt, input logic ovf, input logic ill,
                            input logic [3:0] tag);
    check({name, " valid"}, bus.out_valid, 1);
    check({name, " res"},   bus.data_result, res);
    check({name, " ne"},    bus.isNotEqual, ne);
    check({name, " lt"},    bus.isLessThan, lt);
    check({name, " ovf"},   bus.overflow, ovf);
    check({name, " ill"},   bus.illegal_op, ill);
    check({name, " tag"},   bus.out_tag, tag);
  endtask

  // Present one op at the current negedge; expect nothing one cycle later and
  // the result two cycles after it was presented.
  task automatic single(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] amt, input logic [3:0] tag,
                        input logic [31:0] res, input logic ne, input logic lt,
                        input logic ovf, input logic ill);
    drive(op, a, b, amt, tag);
    @(negedge clk);
    idle();
    check({name, " latency"}, bus.out_valid, 0);
    @(negedge clk);
    expect_out(name, res, ne, lt, ovf, ill, tag);
  endtask

  task automatic single16(input string name, input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] amt,
                          input logic [15:0] res, input logic ovf);
    bus16.in_valid       = 1'b1;
    bus16.ctrl_ALUopcode = op;
    bus16.data_operandA  = a;
    bus16.data_operandB  = b;
    bus16.ctrl_shiftamt  = amt;
    bus16.in_tag         = 4'h7;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    check({name, " latency"}, bus16.out_valid, 0);
    @(negedge clk);
    check({name, " valid"}, bus16.out_valid, 1);
    check({name, " res"},   bus16.data_result, res);
    check({name, " ovf"},   bus16.overflow, ovf);
    check({name, " tag"},   bus16.out_tag, 4'h7);
  endtask

  logic [3:0]  got_tag[$];
  logic [31:0] got_res[$];
  logic [31:0] held_res;
  logic        accepted;
  int          seen;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.data_operandA = '0; bus.data_operandB = '0;
    bus.ctrl_ALUopcode = '0; bus.ctrl_shiftamt = '0; bus.in_tag = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
    bus16.data_operandA = '0; bus16.data_operandB = '0;
    bus16.ctrl_ALUopcode = '0; bus16.ctrl_shiftamt = '0; bus16.in_tag = '0;

    repeat (2) @(negedge clk);
    check("rst in_ready", bus.in_ready, 1);
    check("rst valid", bus.out_valid, 0);
    check("rst res", bus.data_result, 0);
    check("rst tag", bus.out_tag, 0);
    check("rst flags", {bus.isNotEqual, bus.isLessThan, bus.overflow, bus.illegal_op}, 0);
    rst = 1'b0;
    @(negedge clk);

    single("add ovf",  ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 4'h1, 32'h8000_0000, 0, 0, 1, 0);
    single("sub 5-7",  SUB, 32'd5, 32'd7, 5'd0, 4'h2, 32'hFFFF_FFFE, 1, 1, 0, 0);
    single("sub min-1", SUB, 32'h8000_0000, 32'h1, 5'd0, 4'h3, 32'h7FFF_FFFF, 1, 1, 1, 0);
    single("sub 9-9",  SUB, 32'd9, 32'd9, 5'd0, 4'h4, 32'h0, 0, 0, 0, 0);
    single("sra",      SRA, 32'h8000_0001, 32'h0, 5'd4, 4'h5, 32'hF800_0000, 0, 0, 0, 0);
    single("srl",      SRL, 32'h8000_0001, 32'h0, 5'd4, 4'h6, 32'h0800_0000, 0, 0, 0, 0);
    single("rotr",     ROTR, 32'h8000_0001, 32'h0, 5'd4, 4'h7, 32'h1800_0000, 0, 0, 0, 0);
    single("rotr 0",   ROTR, 32'h8000_0001, 32'h0, 5'd0, 4'h8, 32'h8000_0001, 0, 0, 0, 0);
    single("srl 0",    SRL, 32'h8000_0001, 32'h0, 5'd0, 4'h9, 32'h8000_0001, 0, 0, 0, 0);
    single("sll 31",   SLL, 32'h3, 32'h0, 5'd31, 4'hB, 32'h8000_0000, 0, 0, 0, 0);
    single("and",      AND_, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 4'hC, 32'h00F0_1200, 0, 0, 0, 0);
    single("or",       OR_, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 4'hD, 32'hFFF0_FF34, 0, 0, 0, 0);
    single("xor",      XOR_, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 4'hE, 32'hFF00_ED34, 0, 0, 0, 0);
    single("illegal",  5'd15, 32'h1234_5678, 32'h1234_5678, 5'd3, 4'hA, 32'h0, 0, 0, 0, 1);

    // Back-pressure: three back-to-back ops, consumer stalls for three cycles
    drive(ADD, 32'h10, 32'h1, 5'd0, 4'h1);
    @(negedge clk);
    drive(ADD, 32'h20, 32'h1, 5'd0, 4'h2);
    @(negedge clk);
    check("bp first valid", bus.out_valid, 1);
    drive(ADD, 32'h30, 32'h1, 5'd0, 4'h3);
    bus.out_ready = 1'b0;
    #1;
    check("bp in_ready", bus.in_ready, 0);
    held_res = bus.data_result;
    repeat (3) begin
      @(negedge clk);
      check("bp stall in_ready", bus.in_ready, 0);
      check("bp stall valid", bus.out_valid, 1);
      check("bp stall tag", bus.out_tag, 4'h1);
      check("bp stall res", bus.data_result, held_res);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.out_valid) begin
        got_tag.push_back(bus.out_tag);
        got_res.push_back(bus.data_result);
      end
      accepted = bus.in_valid & bus.in_ready;
      @(negedge clk);
      if (accepted) idle();
    end
    check("bp count", got_tag.size(), 3);
    while (got_tag.size() < 3) begin
      got_tag.push_back(4'hF);
      got_res.push_back(32'hDEAD_BEEF);
    end
    check("bp tag0", got_tag[0], 4'h1);
    check("bp tag1", got_tag[1], 4'h2);
    check("bp tag2", got_tag[2], 4'h3);
    check("bp res0", got_res[0], 32'h11);
    check("bp res1", got_res[1], 32'h21);
    check("bp res2", got_res[2], 32'h31);

    // Reset with two ops in flight, while the result channel is stalled
    drive(ADD, 32'h1, 32'h1, 5'd0, 4'h4);
    @(negedge clk);
    drive(ADD, 32'h2, 32'h2, 5'd0, 4'h5);
    @(negedge clk);
    check("rst2 pre valid", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    drive(ADD, 32'h3, 32'h3, 5'd0, 4'h6);
    #1;
    check("rst2 in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    #1;
    check("rst2 valid", bus.out_valid, 0);
    check("rst2 res", bus.data_result, 0);
    check("rst2 tag", bus.out_tag, 0);
    check("rst2 flags", {bus.isNotEqual, bus.isLessThan, bus.overflow, bus.illegal_op}, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst2 no ghost", seen, 0);
    single("post rst", ADD, 32'd100, 32'd23, 5'd0, 4'h9, 32'd123, 0, 0, 0, 0);

    // Narrow instance
    single16("w16 rotr", ROTR, 16'h0001, 16'h0, 4'd1, 16'h8000, 0);
    single16("w16 add",  ADD,  16'h7FFF, 16'h1, 4'd0, 16'h8000, 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
